lcd_cmd_sequencer: RTL and testbench

- Sits between a host command source and the lcd_ctrl core.
- Buffers host commands in a small FIFO and issues them to lcd_ctrl only when its busy is low.
- For load commands (cmd 0), streams IMG_N image bytes from a synchronous image ROM onto lcd datain.
- Counts output_valid pulses so the host knows when a command's output burst has been delivered.

---
 rtl/lcd_cmd_sequencer_if.sv | 36 +++
 rtl/lcd_cmd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : lcd_cmd_sequencer_if
// Brief   : Host, image-ROM and lcd_ctrl signal bundle for lcd_cmd_sequencer.
// Rev     : 1.0
// ============================================================================
interface lcd_cmd_sequencer_if #(
   parameter int ADDR_W = 7
);
   logic [2:0]        host_cmd;
   logic              host_push;
   logic              host_full;
   logic [ADDR_W-1:0] img_addr;
   logic [7:0]        img_data;
   logic [2:0]        lcd_cmd;
   logic              lcd_cmd_valid;
   logic [7:0]        lcd_datain;
   logic              lcd_busy;
   logic              lcd_output_valid;
   logic [15:0]       out_cnt;
   logic              seq_idle;
   logic              err;

   modport slave (
      input  host_cmd, host_push, img_data, lcd_busy, lcd_output_valid,
      output host_full, img_addr, lcd_cmd, lcd_cmd_valid, lcd_datain,
             out_cnt, seq_idle, err
   );

   modport master (
      output host_cmd, host_push, img_data, lcd_busy, lcd_output_valid,
      input  host_full, img_addr, lcd_cmd, lcd_cmd_valid, lcd_datain,
             out_cnt, seq_idle, err
   );
endinterface
`default_nettype wire

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lcd_cmd_sequencer
// Brief   : Queues host commands for lcd_ctrl, streams image bytes on loads and
//           counts output strobes. LCD_SEQ_WATCHDOG_EN adds a busy watchdog.
// Rev     : 1.0
// ============================================================================
module lcd_cmd_sequencer #(
   parameter int IMG_N      = 108,
   parameter int ADDR_W     = 7,
   parameter int FIFO_DEPTH = 4
`ifdef LCD_SEQ_WATCHDOG_EN
   ,
   parameter int TIMEOUT    = 1023
`endif
) (
   input  logic               clk,
   input  logic               reset,
   lcd_cmd_sequencer_if.slave bus
);
   localparam int                PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_N - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_LOAD  = 3'd2,
      S_GUARD = 3'd3,
      S_WAITB = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        mem_q [FIFO_DEPTH];
   logic [2:0]        mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [2:0]        lcd_cmd_q, lcd_cmd_d;
   logic              lcd_cmd_valid_q, lcd_cmd_valid_d;
   logic [7:0]        lcd_datain_q, lcd_datain_d;
   logic [ADDR_W-1:0] img_addr_q, img_addr_d;
   logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [15:0]       out_cnt_q, out_cnt_d;
   logic              seq_idle_q, seq_idle_d;
   logic              err_q, err_d;
   logic              fifo_empty, fifo_full, pop, push_ok, overflow, wd_fire;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   // A pop frees the slot the push lands in, so a push while full still succeeds.
   assign push_ok    = bus.host_push && (!fifo_full || pop);
   assign overflow   = bus.host_push && fifo_full && !pop;

`ifdef LCD_SEQ_WATCHDOG_EN
   logic [9:0] wd_cnt_q, wd_cnt_d;

   always_comb begin
      wd_cnt_d = '0;
      wd_fire  = 1'b0;
      if (state_q == S_WAITB && bus.lcd_busy) begin
         if (wd_cnt_q == 10'(TIMEOUT - 1)) wd_fire = 1'b1;
         else                               wd_cnt_d = wd_cnt_q + 10'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) wd_cnt_q <= '0;
      else       wd_cnt_q <= wd_cnt_d;
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = bus.host_cmd;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      pop             = 1'b0;
      lcd_cmd_d       = lcd_cmd_q;
      lcd_cmd_valid_d = 1'b0;
      lcd_datain_d    = lcd_datain_q;
      img_addr_d      = img_addr_q;
      byte_cnt_d      = byte_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty && !bus.lcd_busy) pop = 1'b1;
         end
         S_ISSUE: begin
            if (lcd_cmd_q == 3'd0) begin
               // Address 0 is on the ROM this cycle; pre-issue address 1.
               state_d    = S_LOAD;
               img_addr_d = ADDR_W'(1);
               byte_cnt_d = '0;
            end else begin
               state_d = S_GUARD;
            end
         end
         S_LOAD: begin
            lcd_datain_d = bus.img_data;
            if (img_addr_q != LAST_ADDR) img_addr_d = img_addr_q + ADDR_W'(1);
            if (byte_cnt_q == LAST_ADDR) state_d = S_GUARD;
            else                         byte_cnt_d = byte_cnt_q + ADDR_W'(1);
         end
         S_GUARD: begin
            state_d = S_WAITB;
         end
         S_WAITB: begin
            if (wd_fire) begin
               state_d = S_IDLE;
            end else if (!bus.lcd_busy) begin
               if (!fifo_empty) pop = 1'b1;
               else             state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Entering ISSUE: the strobe and command are registered from the popped head.
      if (pop) begin
         state_d         = S_ISSUE;
         lcd_cmd_d       = mem_q[rd_ptr_q];
         lcd_cmd_valid_d = 1'b1;
         img_addr_d      = '0;
      end
   end

   assign out_cnt_d  = out_cnt_q + 16'(bus.lcd_output_valid);
   assign seq_idle_d = fifo_empty && (state_q == S_IDLE) && !bus.lcd_busy;
   assign err_d      = err_q | overflow | wd_fire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         lcd_cmd_q       <= '0;
         lcd_cmd_valid_q <= 1'b0;
         lcd_datain_q    <= '0;
         img_addr_q      <= '0;
         byte_cnt_q      <= '0;
         out_cnt_q       <= '0;
         seq_idle_q      <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         mem_q           <= mem_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         lcd_cmd_q       <= lcd_cmd_d;
         lcd_cmd_valid_q <= lcd_cmd_valid_d;
         lcd_datain_q    <= lcd_datain_d;
         img_addr_q      <= img_addr_d;
         byte_cnt_q      <= byte_cnt_d;
         out_cnt_q       <= out_cnt_d;
         seq_idle_q      <= seq_idle_d;
         err_q           <= err_d;
      end
   end

   assign bus.host_full     = fifo_full;
   assign bus.img_addr      = img_addr_q;
   assign bus.lcd_cmd       = lcd_cmd_q;
   assign bus.lcd_cmd_valid = lcd_cmd_valid_q;
   assign bus.lcd_datain    = lcd_datain_q;
   assign bus.out_cnt       = out_cnt_q;
   assign bus.seq_idle      = seq_idle_q;
   assign bus.err           = err_q;
endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_cmd_sequencer
// Brief   : Randomized self-checking bench for lcd_cmd_sequencer (define
//           LCD_SEQ_WATCHDOG_EN to exercise the watchdog with TIMEOUT=20).
// Rev     : 1.0
// ============================================================================
module tb_lcd_cmd_sequencer;
   localparam int IMG_N  = 108;
   localparam int ADDR_W = 7;
   localparam int DEPTH  = 4;
`ifdef LCD_SEQ_WATCHDOG_EN
   localparam int TIMEOUT = 20;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   exp_out_cnt = 0;
   logic [7:0] rom [0:(1<<ADDR_W)-1];
   int         scyc [$];
   logic [2:0] scmd [$];

   lcd_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   lcd_cmd_sequencer #(
      .IMG_N      (IMG_N),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (DEPTH)
`ifdef LCD_SEQ_WATCHDOG_EN
      ,
      .TIMEOUT    (TIMEOUT)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) bus.img_data <= rom[bus.img_addr];

   // Strobe log: every cycle in which the command strobe is high.
   always @(negedge clk) begin
      if (bus.lcd_cmd_valid === 1'b1) begin
         scyc.push_back(cyc);
         scmd.push_back(bus.lcd_cmd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [2:0] c);
      bus.host_cmd  = c;
      bus.host_push = 1'b1;
      tick();
      bus.host_push = 1'b0;
   endtask

   task automatic wait_strobe(input int limit, output bit found);
      found = 1'b0;
      for (int i = 0; i < limit && !found; i++) begin
         if (bus.lcd_cmd_valid === 1'b1) found = 1'b1;
         else                            tick();
      end
   endtask

   task automatic wait_idle(input string tag);
      int i = 0;
      while (bus.seq_idle !== 1'b1 && i < 300) begin
         tick();
         i++;
      end
      n_vec++;
      if (bus.seq_idle !== 1'b1) begin
         n_err++;
         $display("FAIL %s_idle: seq_idle=%b, required 1 within 300 cycles", tag, bus.seq_idle);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_vec++;
      if ({bus.lcd_cmd, bus.lcd_cmd_valid, bus.lcd_datain, bus.img_addr, bus.out_cnt,
           bus.err, bus.host_full, bus.seq_idle} !== 38'd0) begin
         n_err++;
         $display("FAIL reset_values: cmd=%0h vld=%b din=%0h addr=%0h cnt=%0h err=%b full=%b idle=%b, required all 0",
                  bus.lcd_cmd, bus.lcd_cmd_valid, bus.lcd_datain, bus.img_addr, bus.out_cnt,
                  bus.err, bus.host_full, bus.seq_idle);
      end
      reset = 1'b0;
      exp_out_cnt = 0;
      tick();
      n_vec++;
      if (bus.seq_idle !== 1'b1) begin
         n_err++;
         $display("FAIL reset_seq_idle: got %b, required 1", bus.seq_idle);
      end
   endtask

   task automatic test_load();
      bit found;
      for (int k = 0; k < (1 << ADDR_W); k++) rom[k] = 8'($urandom);
      push_cmd(3'd0);
      wait_strobe(10, found);
      n_vec++;
      if (!found || bus.lcd_cmd !== 3'd0) begin
         n_err++;
         $display("FAIL load_strobe: found=%b cmd=%0h, required strobe with cmd 0", found, bus.lcd_cmd);
      end
      if (found) begin
         tick();
         n_vec++;
         if (bus.lcd_cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL load_strobe_width: valid=%b one cycle after strobe, required 0", bus.lcd_cmd_valid);
         end
         for (int k = 0; k < IMG_N; k++) begin
            tick();
            n_vec++;
            if (bus.lcd_datain !== rom[k]) begin
               n_err++;
               $display("FAIL load_byte_%0d: datain=%0h, required %0h", k, bus.lcd_datain, rom[k]);
            end
         end
         for (int i = 0; i < 4; i++) tick();
         n_vec++;
         if (bus.lcd_datain !== rom[IMG_N-1] || bus.lcd_cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL load_hold: datain=%0h valid=%b, required %0h and 0",
                     bus.lcd_datain, bus.lcd_cmd_valid, rom[IMG_N-1]);
         end
      end
      wait_idle("load");
   endtask

   task automatic test_back_to_back();
      logic [2:0] cmds [3];
      int base = scyc.size();
      for (int i = 0; i < 3; i++) cmds[i] = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin
         bus.host_cmd  = cmds[i];
         bus.host_push = 1'b1;
         tick();
      end
      bus.host_push = 1'b0;
      for (int i = 0; i < 25; i++) tick();
      n_vec++;
      if (scyc.size() - base != 3) begin
         n_err++;
         $display("FAIL b2b_count: %0d strobes, required 3", scyc.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (scmd[base+i] !== cmds[i]) begin
               n_err++;
               $display("FAIL b2b_cmd_%0d: cmd=%0h, required %0h", i, scmd[base+i], cmds[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            n_vec++;
            if (scyc[base+i] - scyc[base+i-1] != 3) begin
               n_err++;
               $display("FAIL b2b_spacing_%0d: %0d cycles, required 3", i, scyc[base+i] - scyc[base+i-1]);
            end
         end
      end
      n_vec++;
      if (bus.seq_idle !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_seq_idle: got %b, required 1", bus.seq_idle);
      end
   endtask

   task automatic test_busy_wait();
      bit         found;
      int         nb, pulses, base, b;
      logic [2:0] c_first, c_next;
      c_first = 3'($urandom_range(1, 7));
      c_next  = 3'($urandom_range(1, 7));
      nb      = $urandom_range(8, 20);
      pulses  = 0;
      push_cmd(c_first);
      wait_strobe(10, found);
      n_vec++;
      if (!found || bus.lcd_cmd !== c_first) begin
         n_err++;
         $display("FAIL busy_first_strobe: found=%b cmd=%0h, required %0h", found, bus.lcd_cmd, c_first);
      end
      tick();
      base = scyc.size();
      bus.lcd_busy = 1'b1;
      for (int i = 0; i < nb; i++) begin
         bus.lcd_output_valid = 1'($urandom_range(0, 1));
         pulses += int'(bus.lcd_output_valid);
         bus.host_push = (i == 1);
         bus.host_cmd  = c_next;
         tick();
      end
      bus.host_push = 1'b0;
      bus.lcd_output_valid = 1'b0;
      n_vec++;
      if (scyc.size() != base) begin
         n_err++;
         $display("FAIL busy_no_strobe: %0d strobes while busy, required 0", scyc.size() - base);
      end
      bus.lcd_busy = 1'b0;
      b = cyc;
      base = scyc.size();
      tick();
      tick();
      n_vec++;
      if (scyc.size() - base != 1 || scyc[base] != b + 1 || scmd[base] !== c_next) begin
         n_err++;
         $display("FAIL busy_release_strobe: count=%0d cycle=%0d cmd=%0h, required 1 strobe at %0d cmd %0h",
                  scyc.size() - base, (scyc.size() > base) ? scyc[base] : -1,
                  (scyc.size() > base) ? scmd[base] : 3'h0, b + 1, c_next);
      end
      exp_out_cnt += pulses;
      n_vec++;
      if (bus.out_cnt !== 16'(exp_out_cnt)) begin
         n_err++;
         $display("FAIL busy_out_cnt: got %0d, required %0d", bus.out_cnt, 16'(exp_out_cnt));
      end
      wait_idle("busy");
   endtask

   task automatic test_overflow();
      logic [2:0] model [$];
      logic [2:0] c;
      bit         exp_err = 1'b0;
      int         base;
      bus.lcd_busy = 1'b1;
      base = scyc.size();
      for (int i = 0; i < 5; i++) begin
         c = 3'($urandom_range(1, 7));
         bus.host_cmd  = c;
         bus.host_push = 1'b1;
         tick();
         if (model.size() < DEPTH) model.push_back(c);
         else                      exp_err = 1'b1;
         n_vec++;
         if (bus.host_full !== (model.size() == DEPTH)) begin
            n_err++;
            $display("FAIL ovf_full_after_%0d: host_full=%b, required %b", i + 1, bus.host_full, model.size() == DEPTH);
         end
      end
      bus.host_push = 1'b0;
      n_vec++;
      if (bus.err !== exp_err) begin
         n_err++;
         $display("FAIL ovf_err: got %b, required %b", bus.err, exp_err);
      end
      for (int i = 0; i < 3; i++) tick();
      bus.lcd_busy = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      n_vec++;
      if (scyc.size() - base != model.size()) begin
         n_err++;
         $display("FAIL ovf_issue_count: %0d strobes, required %0d", scyc.size() - base, model.size());
      end else begin
         for (int i = 0; i < model.size(); i++) begin
            n_vec++;
            if (scmd[base+i] !== model[i]) begin
               n_err++;
               $display("FAIL ovf_cmd_%0d: cmd=%0h, required %0h", i, scmd[base+i], model[i]);
            end
         end
      end
      wait_idle("ovf");
   endtask

   task automatic test_reset_midburst();
      bit found;
      int base;
      for (int k = 0; k < (1 << ADDR_W); k++) rom[k] = 8'($urandom);
      push_cmd(3'd0);
      wait_strobe(10, found);
      n_vec++;
      if (!found) begin
         n_err++;
         $display("FAIL rst_burst_strobe: no strobe within 10 cycles, required 1");
      end
      for (int k = 1; k <= 52; k++) begin
         bus.host_push = (k <= 2);
         bus.host_cmd  = (k == 1) ? 3'd3 : 3'd5;
         tick();
      end
      bus.host_push = 1'b0;
      n_vec++;
      if (bus.lcd_datain !== rom[50]) begin
         n_err++;
         $display("FAIL rst_burst_byte50: datain=%0h, required %0h", bus.lcd_datain, rom[50]);
      end
      #2;
      reset = 1'b1;
      #1;
      n_vec++;
      if ({bus.lcd_cmd, bus.lcd_cmd_valid, bus.lcd_datain, bus.img_addr, bus.out_cnt,
           bus.err, bus.host_full} !== 37'd0) begin
         n_err++;
         $display("FAIL rst_burst_async: cmd=%0h vld=%b din=%0h addr=%0h cnt=%0h err=%b full=%b, required all 0",
                  bus.lcd_cmd, bus.lcd_cmd_valid, bus.lcd_datain, bus.img_addr, bus.out_cnt,
                  bus.err, bus.host_full);
      end
      exp_out_cnt = 0;
      tick();
      tick();
      reset = 1'b0;
      base = scyc.size();
      for (int i = 0; i < 20; i++) tick();
      n_vec++;
      if (scyc.size() != base || bus.seq_idle !== 1'b1) begin
         n_err++;
         $display("FAIL rst_burst_after: strobes=%0d seq_idle=%b, required 0 and 1", scyc.size() - base, bus.seq_idle);
      end
   endtask

   task automatic test_watchdog();
      bit found;
      int base;
      push_cmd(3'd1);
      wait_strobe(10, found);
      n_vec++;
      if (!found || bus.lcd_cmd !== 3'd1) begin
         n_err++;
         $display("FAIL wd_strobe: found=%b cmd=%0h, required strobe with cmd 1", found, bus.lcd_cmd);
      end
      bus.lcd_busy = 1'b1;
`ifdef LCD_SEQ_WATCHDOG_EN
      for (int i = 0; i < TIMEOUT + 1; i++) tick();
      n_vec++;
      if (bus.err !== 1'b0) begin
         n_err++;
         $display("FAIL wd_early: err=%b before %0d busy cycles, required 0", bus.err, TIMEOUT);
      end
      tick();
      n_vec++;
      if (bus.err !== 1'b1) begin
         n_err++;
         $display("FAIL wd_fire: err=%b after %0d busy cycles, required 1", bus.err, TIMEOUT);
      end
`else
      for (int i = 0; i < 40; i++) tick();
      n_vec++;
      if (bus.err !== 1'b0) begin
         n_err++;
         $display("FAIL wd_disabled_err: err=%b with busy stuck, required 0", bus.err);
      end
`endif
      base = scyc.size();
      bus.lcd_busy = 1'b0;
      wait_idle("wd");
      n_vec++;
      if (scyc.size() != base) begin
         n_err++;
         $display("FAIL wd_no_strobe: %0d strobes after release, required 0", scyc.size() - base);
      end
   endtask

   initial begin
      bus.host_cmd         = 3'd0;
      bus.host_push        = 1'b0;
      bus.lcd_busy         = 1'b0;
      bus.lcd_output_valid = 1'b0;
      for (int k = 0; k < (1 << ADDR_W); k++) rom[k] = 8'(k + 1);
      test_reset();
      test_load();
      test_back_to_back();
      test_busy_wait();
      test_overflow();
      test_reset_midburst();
      test_watchdog();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded 500000 time units, required completion");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
